vlog_literal_emitter: RTL

//   Formats a binary value as Verilog sized-literal text (e.g. 8'ha5, 6'o02, 32'd42).

---
 rtl/vlog_literal_emitter.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/vlog_literal_emitter.sv
// Formats a binary value as a Verilog sized literal (e.g. 8'ha5, 32'd42) and streams
// the ASCII characters out over a valid/ready byte interface.
module vlog_literal_emitter #(
    parameter int MAX_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MAX_W-1:0] in_value,
    input  logic [5:0]       in_width,
    input  logic [1:0]       in_radix,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_last,
    output logic             busy
);

    // Decimal digits needed for 2^MAX_W - 1 (floor(MAX_W*log10(2)) + 1).
    localparam int NDEC = (MAX_W * 30103) / 100000 + 1;
    localparam int BW   = 4 * NDEC;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WIDTH,
        S_TICK,
        S_RADIX,
        S_CONV,
        S_DIGITS
    } state_t;

    state_t           state_q, state_d;
    logic [MAX_W-1:0] value_q, value_d;
    logic [5:0]       width_q, width_d;
    logic [1:0]       radix_q, radix_d;
    logic             tens_q, tens_d;
    logic [5:0]       idx_q, idx_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [BW-1:0]    bcd_q, bcd_d;

    logic [5:0]       w_eff;
    logic [MAX_W-1:0] mask;
    logic [7:0]       shamt;
    logic [MAX_W+3:0] shifted;
    logic [3:0]       bin_digit;
    logic [3:0]       dec_digit;
    logic [BW-1:0]    bcd_adj;
    logic [BW-1:0]    bcd_step;
    logic [5:0]       lead;

    function automatic logic [7:0] ascii_digit(input logic [3:0] d);
        return (d < 4'd10) ? (8'h30 + {4'h0, d}) : (8'h57 + {4'h0, d});
    endfunction

    // Datapath helpers: width/mask at accept, digit extraction, one double-dabble step.
    always_comb begin
        w_eff = (in_width == 6'd0 || in_width > 6'(MAX_W)) ? 6'(MAX_W) : in_width;
        mask  = {MAX_W{1'b1}} >> (6'(MAX_W) - w_eff);

        case (radix_q)
            2'd0:    shamt = {2'b00, idx_q};
            2'd1:    shamt = 8'(idx_q) * 8'd3;
            2'd3:    shamt = {idx_q, 2'b00};
            default: shamt = 8'd0;
        endcase
        shifted = {4'b0000, value_q} >> shamt;
        case (radix_q)
            2'd0:    bin_digit = {3'b000, shifted[0]};
            2'd1:    bin_digit = {1'b0, shifted[2:0]};
            default: bin_digit = shifted[3:0];
        endcase

        dec_digit = 4'd0;
        for (int i = 0; i < NDEC; i++) begin
            if (idx_q == 6'(i)) dec_digit = bcd_q[4*i +: 4];
        end

        bcd_adj = bcd_q;
        for (int i = 0; i < NDEC; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        if (BW > 1) bcd_step = {bcd_adj[BW-2:0], value_q[MAX_W-1]};
        else        bcd_step = value_q[MAX_W-1];

        lead = 6'd0;
        for (int i = 0; i < NDEC; i++) begin
            if (bcd_step[4*i +: 4] != 4'd0) lead = 6'(i);
        end
    end

    // Next-state and output logic; outputs are decoded from the registered state
    // so they stay put while the sink stalls.
    always_comb begin
        state_d   = state_q;
        value_d   = value_q;
        width_d   = width_q;
        radix_d   = radix_q;
        tens_d    = tens_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = 8'h00;
        out_last  = 1'b0;

        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    value_d = in_value & mask;
                    width_d = w_eff;
                    radix_d = in_radix;
                    tens_d  = (w_eff >= 6'd10);
                    state_d = S_WIDTH;
                end
            end
            S_WIDTH: begin
                out_valid = 1'b1;
                out_data  = tens_q ? ascii_digit(4'(width_q / 6'd10))
                                   : ascii_digit(4'(width_q % 6'd10));
                if (out_ready) begin
                    if (tens_q) tens_d  = 1'b0;
                    else        state_d = S_TICK;
                end
            end
            S_TICK: begin
                out_valid = 1'b1;
                out_data  = 8'h27;
                if (out_ready) state_d = S_RADIX;
            end
            S_RADIX: begin
                out_valid = 1'b1;
                case (radix_q)
                    2'd0:    out_data = 8'h62;
                    2'd1:    out_data = 8'h6f;
                    2'd2:    out_data = 8'h64;
                    default: out_data = 8'h68;
                endcase
                if (out_ready) begin
                    case (radix_q)
                        2'd0:    idx_d = width_q - 6'd1;
                        2'd1:    idx_d = (width_q + 6'd2) / 6'd3 - 6'd1;
                        2'd3:    idx_d = (width_q + 6'd3) / 6'd4 - 6'd1;
                        default: idx_d = 6'd0;
                    endcase
                    if (radix_q == 2'd2) begin
                        cnt_d   = 6'd0;
                        bcd_d   = '0;
                        state_d = S_CONV;
                    end else begin
                        state_d = S_DIGITS;
                    end
                end
            end
            S_CONV: begin
                bcd_d   = bcd_step;
                value_d = value_q << 1;
                cnt_d   = cnt_q + 6'd1;
                if (cnt_q == 6'(MAX_W - 1)) begin
                    idx_d   = lead;
                    state_d = S_DIGITS;
                end
            end
            S_DIGITS: begin
                out_valid = 1'b1;
                out_data  = ascii_digit((radix_q == 2'd2) ? dec_digit : bin_digit);
                out_last  = (idx_q == 6'd0);
                if (out_ready) begin
                    if (idx_q == 6'd0) state_d = S_IDLE;
                    else               idx_d   = idx_q - 6'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            value_q <= '0;
            width_q <= '0;
            radix_q <= '0;
            tens_q  <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            width_q <= width_d;
            radix_q <= radix_d;
            tens_q  <= tens_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
        end
    end

endmodule
